// File: rtl/ppu_vram_port.sv
// ppu_vram_port
// CPU-side PPU register port: PPUCTRL ($2000), PPUSTATUS ($2002),
// PPUADDR ($2006) and PPUDATA ($2007). It turns the 14-bit VRAM address v
// into accesses to the 1 KiB name table and the two pattern-table planes.
// The renderer has its own read ports on those memories.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_we, cpu_re             one-cycle register write / read strobes
//   cpu_reg, cpu_din           register select ($2000 + n), write data
//   cpu_dout                   registered read data, held between reads
//   vblank                     vertical blank level from the timing block
//   nmi                        vblank_flag AND ctrl nmi_en
//   we_ntable, addr_ntable_w   name table write strobe / access address
//   we_ptable0, we_ptable1     pattern plane write strobes
//   addr_ptable_w              pattern access address {tile, row}
//   d_vram_w                   write data shared by all memories
//   q_ntable, q_ptable0/1      combinational memory read data
module ppu_vram_port #(
  parameter int C_MEMW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [2:0]        cpu_reg,
  input  logic [C_MEMW-1:0] cpu_din,
  output logic [C_MEMW-1:0] cpu_dout,
  input  logic              vblank,
  output logic              nmi,
  output logic              we_ntable,
  output logic [9:0]        addr_ntable_w,
  output logic              we_ptable0,
  output logic              we_ptable1,
  output logic [10:0]       addr_ptable_w,
  output logic [C_MEMW-1:0] d_vram_w,
  input  logic [C_MEMW-1:0] q_ntable,
  input  logic [C_MEMW-1:0] q_ptable0,
  input  logic [C_MEMW-1:0] q_ptable1
);

  typedef enum logic [1:0] {SEL_NONE, SEL_NT, SEL_PT0, SEL_PT1} sel_t;

  logic              ctrl_inc_q, ctrl_inc_d;
  logic              ctrl_bg_q, ctrl_bg_d;
  logic              ctrl_nmi_q, ctrl_nmi_d;
  logic [13:0]       v_q, v_d;
  logic [5:0]        t_q, t_d;          // high byte of t (t[13:8])
  logic              w_q, w_d;
  logic              vblank_prev_q, vblank_prev_d;
  logic              vblank_flag_q, vblank_flag_d;
  logic [C_MEMW-1:0] buf_q, buf_d;
  logic              rd_pend_q, rd_pend_d;
  sel_t              rd_sel_q, rd_sel_d;
  logic              we_nt_q, we_nt_d;
  logic              we_p0_q, we_p0_d;
  logic              we_p1_q, we_p1_d;
  logic [9:0]        addr_nt_q, addr_nt_d;
  logic [10:0]       addr_pt_q, addr_pt_d;
  logic [C_MEMW-1:0] dvram_q, dvram_d;
  logic [C_MEMW-1:0] dout_q, dout_d;

  sel_t              sel_v;
  logic [13:0]       inc;
  logic [C_MEMW-1:0] q_sel;
  logic              wr, rd;

  // A simultaneous write and read performs only the write.
  assign wr  = cpu_we;
  assign rd  = cpu_re & ~cpu_we;
  assign inc = ctrl_inc_q ? 14'd32 : 14'd1;

  // Address decode of the current v. Only the pattern table selected by
  // bg_sel is backed by memory; the palette range is unmapped.
  always_comb begin
    sel_v = SEL_NONE;
    if (!v_q[13]) begin
      if (v_q[12] == ctrl_bg_q) sel_v = v_q[3] ? SEL_PT1 : SEL_PT0;
    end else if (v_q[13:8] != 6'h3F) begin
      sel_v = SEL_NT;
    end
  end

  // Read data of the memory addressed by the previous PPUDATA read.
  always_comb begin
    unique case (rd_sel_q)
      SEL_NT:  q_sel = q_ntable;
      SEL_PT0: q_sel = q_ptable0;
      SEL_PT1: q_sel = q_ptable1;
      default: q_sel = '0;
    endcase
  end

  always_comb begin
    ctrl_inc_d    = ctrl_inc_q;
    ctrl_bg_d     = ctrl_bg_q;
    ctrl_nmi_d    = ctrl_nmi_q;
    v_d           = v_q;
    t_d           = t_q;
    w_d           = w_q;
    vblank_prev_d = vblank;
    vblank_flag_d = vblank_flag_q;
    buf_d         = buf_q;
    rd_pend_d     = 1'b0;
    rd_sel_d      = rd_sel_q;
    we_nt_d       = 1'b0;
    we_p0_d       = 1'b0;
    we_p1_d       = 1'b0;
    addr_nt_d     = addr_nt_q;
    addr_pt_d     = addr_pt_q;
    dvram_d       = dvram_q;
    dout_d        = dout_q;

    // Memory data for a read issued last cycle lands in the buffer.
    if (rd_pend_q) buf_d = q_sel;

    // Status flag: read-clear first so that a coincident rising edge wins.
    if (rd && cpu_reg == 3'd2) vblank_flag_d = 1'b0;
    if (vblank && !vblank_prev_q) vblank_flag_d = 1'b1;
    if (!vblank && vblank_prev_q) vblank_flag_d = 1'b0;

    if (wr) begin
      unique case (cpu_reg)
        3'd0: begin
          ctrl_inc_d = cpu_din[2];
          ctrl_bg_d  = cpu_din[4];
          ctrl_nmi_d = cpu_din[7];
        end
        3'd6: begin
          if (!w_q) begin
            t_d = cpu_din[5:0];
            w_d = 1'b1;
          end else begin
            v_d = {t_q, cpu_din[7:0]};
            w_d = 1'b0;
          end
        end
        3'd7: begin
          addr_nt_d = v_q[9:0];
          addr_pt_d = {v_q[11:4], v_q[2:0]};
          dvram_d   = cpu_din;
          we_nt_d   = (sel_v == SEL_NT);
          we_p0_d   = (sel_v == SEL_PT0);
          we_p1_d   = (sel_v == SEL_PT1);
          v_d       = v_q + inc;
        end
        default: ;
      endcase
    end else if (rd) begin
      unique case (cpu_reg)
        3'd2: begin
          dout_d = {vblank_flag_q, {(C_MEMW-1){1'b0}}};
          w_d    = 1'b0;
        end
        3'd7: begin
          // Back-to-back reads forward the memory data that is only now
          // being written into the buffer.
          dout_d    = rd_pend_q ? q_sel : buf_q;
          addr_nt_d = v_q[9:0];
          addr_pt_d = {v_q[11:4], v_q[2:0]};
          rd_sel_d  = sel_v;
          rd_pend_d = 1'b1;
          v_d       = v_q + inc;
        end
        default: dout_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_inc_q    <= 1'b0;
      ctrl_bg_q     <= 1'b0;
      ctrl_nmi_q    <= 1'b0;
      v_q           <= '0;
      t_q           <= '0;
      w_q           <= 1'b0;
      vblank_prev_q <= 1'b0;
      vblank_flag_q <= 1'b0;
      buf_q         <= '0;
      rd_pend_q     <= 1'b0;
      rd_sel_q      <= SEL_NONE;
      we_nt_q       <= 1'b0;
      we_p0_q       <= 1'b0;
      we_p1_q       <= 1'b0;
      addr_nt_q     <= '0;
      addr_pt_q     <= '0;
      dvram_q       <= '0;
      dout_q        <= '0;
    end else begin
      ctrl_inc_q    <= ctrl_inc_d;
      ctrl_bg_q     <= ctrl_bg_d;
      ctrl_nmi_q    <= ctrl_nmi_d;
      v_q           <= v_d;
      t_q           <= t_d;
      w_q           <= w_d;
      vblank_prev_q <= vblank_prev_d;
      vblank_flag_q <= vblank_flag_d;
      buf_q         <= buf_d;
      rd_pend_q     <= rd_pend_d;
      rd_sel_q      <= rd_sel_d;
      we_nt_q       <= we_nt_d;
      we_p0_q       <= we_p0_d;
      we_p1_q       <= we_p1_d;
      addr_nt_q     <= addr_nt_d;
      addr_pt_q     <= addr_pt_d;
      dvram_q       <= dvram_d;
      dout_q        <= dout_d;
    end
  end

  assign cpu_dout      = dout_q;
  assign nmi           = vblank_flag_q & ctrl_nmi_q;
  assign we_ntable     = we_nt_q;
  assign we_ptable0    = we_p0_q;
  assign we_ptable1    = we_p1_q;
  assign addr_ntable_w = addr_nt_q;
  assign addr_ptable_w = addr_pt_q;
  assign d_vram_w      = dvram_q;

endmodule
